// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bundle: instruction-memory read port, downstream instruction
// handshake, redirect/halt controls and the busy indicator.
interface fetch_sequencer_if #(
    parameter int unsigned IW = 16
);
    logic          imem_req;
    logic [5:0]    imem_addr;
    logic [IW-1:0] imem_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [IW-1:0] inst_word;
    logic [5:0]    inst_pc;
    logic          br_taken;
    logic [5:0]    br_target;
    logic          halt;
    logic          busy;

    // Fetch sequencer side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        output inst_valid,
        input  inst_ready,
        output inst_word,
        output inst_pc,
        input  br_taken,
        input  br_target,
        input  halt,
        output busy
    );

    // Memory, downstream stage and control side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        input  inst_valid,
        output inst_ready,
        input  inst_word,
        input  inst_pc,
        output br_taken,
        output br_target,
        output halt,
        input  busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: generates the PC, issues single-cycle-latency
// reads to a 64-word instruction memory and buffers returned words in a
// 2-entry FIFO handed downstream through a valid/ready handshake.
module fetch_sequencer #(
    parameter int unsigned IW       = 16,
    parameter logic [5:0]  RESET_PC = 6'd0
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.master bus
);

    logic [5:0]    r_pc;
    logic [1:0]    r_count;
    logic          r_inflight;
    logic [5:0]    r_inflight_pc;
    logic [IW-1:0] r_fifo_word [2];
    logic [5:0]    r_fifo_pc   [2];

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [2:0]    w_credit;
    logic [1:0]    w_wr_idx;
    logic [1:0]    w_count_d;
    logic [IW-1:0] w_word_d [2];
    logic [5:0]    w_pc_d   [2];

    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid & bus.inst_ready;
    assign w_push   = r_inflight;
    // Slots committed after this edge; a pop implies count >= 1, so no underflow.
    assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = !rst & !bus.halt & !bus.br_taken & (w_credit < 3'd2);
    // Tail slot after an optional pop has shifted the queue forward.
    assign w_wr_idx = r_count - {1'b0, w_pop};

    // Next FIFO contents: pop shifts entry 1 to the head, then the return lands at the tail.
    always_comb begin
        w_word_d  = r_fifo_word;
        w_pc_d    = r_fifo_pc;
        w_count_d = r_count;
        if (w_pop) begin
            w_word_d[0] = r_fifo_word[1];
            w_pc_d[0]   = r_fifo_pc[1];
            w_count_d   = r_count - 2'd1;
        end
        if (w_push && (w_wr_idx < 2'd2)) begin
            w_word_d[w_wr_idx[0]] = bus.imem_data;
            w_pc_d[w_wr_idx[0]]   = r_inflight_pc;
            w_count_d             = w_count_d + 2'd1;
        end
    end

    // Control state: reset beats redirect, redirect flushes and drops the in-flight return.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_count       <= 2'd0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 6'd0;
        end else if (bus.br_taken) begin
            r_pc       <= bus.br_target;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_count    <= w_count_d;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 6'd1;
            end
        end
    end

    // FIFO storage needs no reset: the outputs are masked whenever count is zero.
    always_ff @(posedge clk) begin
        r_fifo_word <= w_word_d;
        r_fifo_pc   <= w_pc_d;
    end

    assign bus.imem_req   = w_issue;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst_word  = w_valid ? r_fifo_word[0] : '0;
    assign bus.inst_pc    = w_valid ? r_fifo_pc[0] : 6'd0;
    assign bus.busy       = r_inflight | w_valid;

endmodule
